fx2_tx_arbiter: RTL and testbench
=================================

FX2_TX_ARBITER -- requirements
Module: fx2_tx_arbiter

Interface
REQ-001 SHALL have parameter RR_ENABLE, default 1: 1 = round-robin between sources; 0 = fixed priority, source 1 wins.
REQ-002 SHALL have port fx2_clk, input, 1: sole clock, rising edge.
REQ-003 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port rec0_data, input, 32: timetag event record.
REQ-005 SHALL have port rec0_valid, input, 1: rec0_data is valid.
REQ-006 SHALL have port rec0_ready, output, 1: record 0 captured this cycle.
REQ-007 SHALL have ports rec1_data (input, 32), rec1_valid (input, 1) and rec1_ready (output, 1): register-readback record channel, same semantics as source 0.
REQ-008 SHALL have port fpga_word, output, 8: byte presented to the FX2 interface.
REQ-009 SHALL have port fpga_word_avail, output, 1: fpga_word is valid.
REQ-010 SHALL have port fpga_word_accepted, input, 1: the FX2 interface took fpga_word this cycle.
REQ-011 SHALL have port request_length, input, 1: single-cycle pulse that snapshots and clears the byte count.
REQ-012 SHALL have port length, output, 16: bytes sent before the last request_length.
REQ-013 SHALL have port grant, output, 2: one-hot source of the record in flight; 00 when idle.

Function
REQ-014 SHALL use FSM states IDLE and SEND plus a 2-bit byte index and a 32-bit shift register.
REQ-015 A record transfer SHALL occur when recN_valid and recN_ready are both high; recN_ready SHALL be combinational and high for at most one source per cycle.
REQ-016 In IDLE with any valid: SHALL grant per arbitration, assert that ready, capture the data, set index 0 and enter SEND next cycle.
REQ-017 Arbitration with both valid: RR_ENABLE=1 SHALL grant the source not granted last (register last_grant, reset so source 0 wins first); RR_ENABLE=0 SHALL grant source 1.
REQ-018 In SEND: fpga_word_avail SHALL be 1 and fpga_word SHALL be shift register [31:24], so the record goes out MSB byte first.
REQ-019 On fpga_word_accepted in SEND: SHALL shift left 8 and increment the index; with no accept, fpga_word SHALL hold stable.
REQ-020 On accept of byte index 3: if any valid, SHALL arbitrate and capture in that same cycle and stay in SEND (back-to-back, no bubble); else SHALL go to IDLE.
REQ-021 Records SHALL be atomic: no source switch and no ready assertion until all 4 bytes are accepted.
REQ-022 fpga_word_accepted while not in SEND SHALL be ignored.
REQ-023 Latency: byte 0 of a record captured in cycle N SHALL be presented in cycle N+1.
REQ-024 Byte counter (16-bit) SHALL increment on each accepted byte and saturate at 0xFFFF.
REQ-025 On request_length: length SHALL load counter + accept_this_cycle (saturated), and the counter SHALL clear to 0. An accept in that same cycle SHALL count only in the snapshot.
REQ-026 length SHALL hold its value between request_length pulses.
REQ-027 grant SHALL equal the one-hot source in SEND and 00 in IDLE.

Reset
REQ-028 reset_n low SHALL asynchronously force: state IDLE, index 0, shift register 0, counter 0, length 0, last_grant = source 1.
REQ-029 During reset: fpga_word_avail, rec0_ready, rec1_ready and grant SHALL be 0, and fpga_word SHALL be 0x00.
REQ-030 Reset mid-record SHALL discard the partial record; after release, no leftover bytes SHALL be emitted.

Structure
REQ-031 Package fx2_arb_pkg SHALL hold the state enum, REC_BYTES=4 and LEN_W=16.
REQ-032 The two-way round-robin/priority picker SHALL be the sub-module fx2_rr_arb2 (inputs: req[1:0], last_grant, rr_enable; output: one-hot gnt).

Verification
REQ-033 Single record: rec0 0xA1B2C3D4 with accept always 1 -> bytes A1, B2, C3, D4 on consecutive cycles; rec0_ready for 1 cycle; then request_length -> length=4.
REQ-034 Backpressure: accept low 3 cycles at byte C3 -> fpga_word holds C3 and avail holds 1; no byte lost or duplicated.
REQ-035 Contention, RR_ENABLE=1: both sources valid continuously, records 0x00000000/0x11111111 -> records alternate 0,1,0,1 with no idle cycle between them; RR_ENABLE=0 -> source 1 only.
REQ-036 Snapshot race: request_length in the same cycle as accept of byte 2 (counter=2) -> length=3 and counter=0; next 2 accepts then request_length -> length=2.
REQ-037 Saturation: 65540 accepted bytes -> length=0xFFFF.
REQ-038 Mid-record reset: reset_n low after 2 accepted bytes -> avail=0 immediately; after release with no valid, no bytes emitted and length=0.

Source files
------------

// File: rtl/fx2_arb_pkg.sv
// Shared types and constants for the FX2 transmit arbiter.
// Holds the FSM state enum, record geometry and the byte-counter helper.
package fx2_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int REC_BYTES = 4;
  localparam int LEN_W     = 16;

  localparam logic [1:0] LAST_IDX = 2'(REC_BYTES - 1);

  function automatic logic [LEN_W-1:0] sat_inc(
    input logic [LEN_W-1:0] v,
    input logic             inc
  );
    if (inc && (v != {LEN_W{1'b1}}))
      return v + 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fx2_rr_arb2.sv
// Two-way picker: round-robin on last_grant or fixed priority to source 1.
// Ports: req[1:0] requests, last_grant (1 = source 1), rr_enable, gnt one-hot.
module fx2_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       rr_enable,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        if (rr_enable)
          gnt = last_grant ? 2'b01 : 2'b10;
        else
          gnt = 2'b10;
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/fx2_tx_arbiter.sv
// Serialises 32-bit records from two sources into FX2 bytes, MSB first.
// Ports: rec0/rec1 valid-ready record inputs, fpga_word byte output, length.
module fx2_tx_arbiter
  import fx2_arb_pkg::*;
#(
  parameter int RR_ENABLE = 1
) (
  input  logic             fx2_clk,
  input  logic             reset_n,
  input  logic [31:0]      rec0_data,
  input  logic             rec0_valid,
  output logic             rec0_ready,
  input  logic [31:0]      rec1_data,
  input  logic             rec1_valid,
  output logic             rec1_ready,
  output logic [7:0]       fpga_word,
  output logic             fpga_word_avail,
  input  logic             fpga_word_accepted,
  input  logic             request_length,
  output logic [LEN_W-1:0] length,
  output logic [1:0]       grant
);

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [31:0]      sh_q, sh_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             last_q, last_d;
  logic [1:0]       gnt_q, gnt_d;

  logic [1:0]       pick;
  logic             send;
  logic             acc;
  logic             done;
  logic             cap;
  logic [LEN_W-1:0] cnt_inc;

  fx2_rr_arb2 u_arb (
    .req        ({rec1_valid, rec0_valid}),
    .last_grant (last_q),
    .rr_enable  (RR_ENABLE != 0),
    .gnt        (pick)
  );

  assign send = (state_q == SEND);
  assign acc  = send & fpga_word_accepted;
  assign done = acc & (idx_q == LAST_IDX);

  // Capture only when idle or when the final byte leaves this cycle;
  // reset_n gating keeps both readies low while reset is asserted.
  assign cap = reset_n & (~send | done) & (|pick);

  assign rec0_ready = cap & pick[0];
  assign rec1_ready = cap & pick[1];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    len_d   = len_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    cnt_inc = sat_inc(cnt_q, acc);
    cnt_d   = cnt_inc;

    // A same-cycle accept lands in the snapshot, not the new count.
    if (request_length) begin
      len_d = cnt_inc;
      cnt_d = '0;
    end

    if (acc) begin
      sh_d  = {sh_q[23:0], 8'h00};
      idx_d = idx_q + 2'd1;
    end

    if (done) begin
      state_d = IDLE;
      gnt_d   = 2'b00;
    end

    if (cap) begin
      sh_d    = pick[1] ? rec1_data : rec0_data;
      idx_d   = 2'd0;
      state_d = SEND;
      gnt_d   = pick;
      last_d  = pick[1];
    end
  end

  always_ff @(posedge fx2_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      sh_q    <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      last_q  <= 1'b1;
      gnt_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
    end
  end

  assign fpga_word       = sh_q[31:24];
  assign fpga_word_avail = send;
  assign length          = len_q;
  assign grant           = gnt_q;

endmodule

// File: tb/tb_fx2_tx_arbiter.sv
// Scoreboard bench for fx2_tx_arbiter (round-robin and fixed-priority).
// Expected bytes queue per record; a negedge monitor pops on each accept.
module tb_fx2_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] r0d = '0;
  logic [31:0] r1d = '0;
  logic        r0v = 1'b0;
  logic        r1v = 1'b0;
  logic        acc = 1'b0;
  logic        rql = 1'b0;

  logic        r0r, r1r, avail;
  logic [7:0]  word;
  logic [15:0] len;
  logic [1:0]  gnt;

  logic        p_r0r, p_r1r, p_avail;
  logic [7:0]  p_word;
  logic [15:0] p_len;
  logic [1:0]  p_gnt;

  int errs = 0;
  int checks = 0;
  bit sb_en = 1'b1;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  fx2_tx_arbiter #(.RR_ENABLE(1)) dut (
    .fx2_clk            (clk),
    .reset_n            (reset_n),
    .rec0_data          (r0d),
    .rec0_valid         (r0v),
    .rec0_ready         (r0r),
    .rec1_data          (r1d),
    .rec1_valid         (r1v),
    .rec1_ready         (r1r),
    .fpga_word          (word),
    .fpga_word_avail    (avail),
    .fpga_word_accepted (acc),
    .request_length     (rql),
    .length             (len),
    .grant              (gnt)
  );

  fx2_tx_arbiter #(.RR_ENABLE(0)) dut_p (
    .fx2_clk            (clk),
    .reset_n            (reset_n),
    .rec0_data          (r0d),
    .rec0_valid         (r0v),
    .rec0_ready         (p_r0r),
    .rec1_data          (r1d),
    .rec1_valid         (r1v),
    .rec1_ready         (p_r1r),
    .fpga_word          (p_word),
    .fpga_word_avail    (p_avail),
    .fpga_word_accepted (acc),
    .request_length     (rql),
    .length             (p_len),
    .grant              (p_gnt)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rec(input logic [31:0] d);
    for (int i = 0; i < 4; i++)
      exp_q.push_back(d[8*(3-i) +: 8]);
  endtask

  always @(negedge clk) begin
    if (sb_en && reset_n && avail && acc) begin
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL extra_byte: got %h want none", word);
      end else begin
        chk("byte", {24'h0, word}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    // Reset state, with a valid pending to prove ready is gated
    r0v = 1'b1;
    r0d = 32'hCAFEF00D;
    #12;
    @(negedge clk);
    chk("rst_avail", {31'h0, avail}, 32'h0);
    chk("rst_r0r", {31'h0, r0r}, 32'h0);
    chk("rst_r1r", {31'h0, r1r}, 32'h0);
    chk("rst_gnt", {30'h0, gnt}, 32'h0);
    chk("rst_word", {24'h0, word}, 32'h0);
    chk("rst_len", {16'h0, len}, 32'h0);
    tick();
    r0v = 1'b0;
    reset_n = 1'b1;

    // Single record, accept always high
    r0d = 32'hA1B2C3D4;
    r0v = 1'b1;
    acc = 1'b1;
    push_rec(r0d);
    @(negedge clk);
    chk("t1_r0r_cap", {31'h0, r0r}, 32'h1);
    chk("t1_gnt_idle", {30'h0, gnt}, 32'h0);
    tick();
    r0v = 1'b0;
    @(negedge clk);
    chk("t1_r0r_after", {31'h0, r0r}, 32'h0);
    chk("t1_gnt_send", {30'h0, gnt}, 32'h1);
    chk("t1_word0", {24'h0, word}, 32'hA1);
    repeat (3) tick();
    tick();
    @(negedge clk);
    chk("t1_idle", {31'h0, avail}, 32'h0);
    chk("t1_gnt_end", {30'h0, gnt}, 32'h0);
    rql = 1'b1;
    tick();
    rql = 1'b0;
    @(negedge clk);
    chk("t1_len", {16'h0, len}, 32'd4);
    chk("t1_q_empty", exp_q.size(), 32'd0);

    // Backpressure at byte C3
    tick();
    r0v = 1'b1;
    push_rec(r0d);
    tick();
    r0v = 1'b0;
    tick();
    tick();
    acc = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t2_hold_word", {24'h0, word}, 32'hC3);
      chk("t2_hold_avail", {31'h0, avail}, 32'h1);
      tick();
    end
    acc = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("t2_idle", {31'h0, avail}, 32'h0);
    rql = 1'b1;
    tick();
    rql = 1'b0;
    @(negedge clk);
    chk("t2_len", {16'h0, len}, 32'd4);
    chk("t2_q_empty", exp_q.size(), 32'd0);

    // Fresh reset so round-robin starts from source 0
    tick();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;

    // Contention: alternate in RR, source 1 only in fixed priority
    r0d = 32'h00000000;
    r1d = 32'h11111111;
    r0v = 1'b1;
    r1v = 1'b1;
    acc = 1'b1;
    push_rec(r0d);
    push_rec(r1d);
    push_rec(r0d);
    push_rec(r1d);
    @(negedge clk);
    chk("t3_first_r0", {31'h0, r0r}, 32'h1);
    chk("t3_p_first_r1", {31'h0, p_r1r}, 32'h1);
    tick();
    for (int i = 1; i <= 16; i++) begin
      if (i == 13) begin
        r0v = 1'b0;
        r1v = 1'b0;
      end
      @(negedge clk);
      chk("t3_avail", {31'h0, avail}, 32'h1);
      chk("t3_gnt", {30'h0, gnt},
          (((i - 1) / 4) % 2 == 1) ? 32'h2 : 32'h1);
      chk("t3_p_avail", {31'h0, p_avail}, 32'h1);
      chk("t3_p_gnt", {30'h0, p_gnt}, 32'h2);
      chk("t3_p_word", {24'h0, p_word}, 32'h11);
      tick();
    end
    @(negedge clk);
    chk("t3_idle", {31'h0, avail}, 32'h0);
    chk("t3_p_idle", {31'h0, p_avail}, 32'h0);
    rql = 1'b1;
    tick();
    rql = 1'b0;
    @(negedge clk);
    chk("t3_len", {16'h0, len}, 32'd16);
    chk("t3_q_empty", exp_q.size(), 32'd0);

    // Snapshot race with accept of byte 2
    tick();
    r0d = 32'hA1B2C3D4;
    r0v = 1'b1;
    push_rec(r0d);
    tick();
    r0v = 1'b0;
    tick();
    tick();
    rql = 1'b1;
    tick();
    rql = 1'b0;
    r0d = 32'h55667788;
    r0v = 1'b1;
    push_rec(r0d);
    @(negedge clk);
    chk("t4_len_race", {16'h0, len}, 32'd3);
    tick();
    r0v = 1'b0;
    tick();
    acc = 1'b0;
    rql = 1'b1;
    tick();
    rql = 1'b0;
    acc = 1'b1;
    @(negedge clk);
    chk("t4_len_after", {16'h0, len}, 32'd2);
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("t4_idle", {31'h0, avail}, 32'h0);
    chk("t4_len_hold", {16'h0, len}, 32'd2);
    chk("t4_q_empty", exp_q.size(), 32'd0);

    // Reset after two accepted bytes
    tick();
    r0d = 32'hDEADBEEF;
    r0v = 1'b1;
    push_rec(r0d);
    tick();
    r0v = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk("t5_rst_avail", {31'h0, avail}, 32'h0);
    chk("t5_rst_gnt", {30'h0, gnt}, 32'h0);
    chk("t5_rst_word", {24'h0, word}, 32'h0);
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t5_no_bytes", {31'h0, avail}, 32'h0);
      tick();
    end
    rql = 1'b1;
    tick();
    rql = 1'b0;
    @(negedge clk);
    chk("t5_len", {16'h0, len}, 32'd0);

    // Saturation of the byte counter
    sb_en = 1'b0;
    tick();
    r0d = 32'h12345678;
    r0v = 1'b1;
    repeat (65545) tick();
    r0v = 1'b0;
    begin
      int n;
      n = 0;
      while (avail && n < 10) begin
        tick();
        n++;
      end
    end
    chk("t6_idle", {31'h0, avail}, 32'h0);
    rql = 1'b1;
    tick();
    rql = 1'b0;
    @(negedge clk);
    chk("t6_len_sat", {16'h0, len}, 32'hFFFF);
    chk("t6_p_len_sat", {16'h0, p_len}, 32'hFFFF);
    chk("final_q_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
